// File: rtl/grf_sb_if.sv
// Bundle of the grf_sb write, issue and read ports.
// The master side drives writes, issues and read addresses; the slave side returns data and busy.
interface grf_sb_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          iss;
    logic [AW-1:0] isa;
    logic          busy1;
    logic          busy2;
    logic [AW:0]   npend;

    modport master (
        output we, wa, wd, ra1, ra2, iss, isa,
        input  rd1, rd2, busy1, busy2, npend
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, iss, isa,
        output rd1, rd2, busy1, busy2, npend
    );
endinterface

// File: rtl/grf_sb.sv
// General register file with a per-register pending scoreboard, two async read ports.
// Optional macro GRF_SB_BYPASS_EN forwards same-cycle write data to the read ports.
module grf_sb #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic      clk,
    input  logic      reset,
    grf_sb_if.slave   bus
);
    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned CW   = AW + 1;

    logic [DW-1:0]   mem [NREG];
    logic [NREG-1:0] pend;
    logic [CW-1:0]   npend_q;

    logic            wr_ok;
    logic            is_ok;
    logic            inc;
    logic            dec;
    logic [NREG-1:0] pend_nxt;
    logic [CW-1:0]   npend_nxt;

    // Scoreboard update: write clears, issue sets, issue wins on a collision.
    always_comb begin
        wr_ok     = bus.we  && (bus.wa  != '0);
        is_ok     = bus.iss && (bus.isa != '0);
        pend_nxt  = pend;
        if (wr_ok) pend_nxt[bus.wa]  = 1'b0;
        if (is_ok) pend_nxt[bus.isa] = 1'b1;
        inc       = is_ok && !pend[bus.isa];
        dec       = wr_ok && pend[bus.wa] && !(is_ok && (bus.isa == bus.wa));
        npend_nxt = npend_q + CW'(inc) - CW'(dec);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem     <= '{default: '0};
            pend    <= '0;
            npend_q <= '0;
        end else begin
            if (wr_ok) mem[bus.wa] <= bus.wd;
            pend    <= pend_nxt;
            npend_q <= npend_nxt;
        end
    end

    assign bus.npend = npend_q;

    // Asynchronous read ports; register 0 always reads as zero and never busy.
    always_comb begin
        bus.rd1   = mem[bus.ra1];
        bus.busy1 = pend[bus.ra1];
        bus.rd2   = mem[bus.ra2];
        bus.busy2 = pend[bus.ra2];
`ifdef GRF_SB_BYPASS_EN
        if (reset && wr_ok && (bus.wa == bus.ra1)) begin
            bus.rd1   = bus.wd;
            bus.busy1 = 1'b0;
        end
        if (reset && wr_ok && (bus.wa == bus.ra2)) begin
            bus.rd2   = bus.wd;
            bus.busy2 = 1'b0;
        end
`endif
        if (bus.ra1 == '0) begin
            bus.rd1   = '0;
            bus.busy1 = 1'b0;
        end
        if (bus.ra2 == '0) begin
            bus.rd2   = '0;
            bus.busy2 = 1'b0;
        end
    end
endmodule
